// File: rtl/srt_radix4_digit_gen.sv
// Radix-4 SRT division recurrence: one signed quotient digit in {-2..2} per clock,
// with exact full-width digit selection against multiples of the divisor.
module srt_radix4_digit_gen #(
    parameter int unsigned N          = 12,
    parameter int unsigned WL         = 24,
    parameter int unsigned RADIX      = 4,
    parameter int unsigned addpointer = $clog2(N + 1)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start,
    input  logic [WL-1:0]         dividend,
    input  logic [WL-1:0]         divisor,
    output logic [2:0]            q,
    output logic [2:0]            q_abs,
    output logic [addpointer-1:0] pointer,
    output logic                  CE,
    output logic                  busy,
    output logic                  done,
    output logic                  rem_neg,
    output logic                  rem_zero,
    output logic                  div_err
);

    // Residual: 4 integer bits (incl. sign), WL+1 fraction bits.
    localparam int unsigned WW = WL + 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (RADIX != 4) begin : g_radix_check
            $error("srt_radix4_digit_gen supports RADIX=4 only");
        end
    endgenerate

    state_t                 r_state, w_state_nxt;
    logic signed [WW-1:0]   r_w, w_w_nxt;
    logic [WL-1:0]          r_d, w_d_nxt;
    logic [addpointer-1:0]  r_cnt, w_cnt_nxt;
    logic                   r_bad, w_bad_nxt;

    logic [2:0]             w_q_nxt, w_qabs_nxt;
    logic [addpointer-1:0]  w_ptr_nxt;
    logic                   w_ce_nxt, w_busy_nxt, w_done_nxt;
    logic                   w_rneg_nxt, w_rzero_nxt, w_err_nxt;

    logic signed [WW-1:0]   w_w4, w_d1, w_half, w_three_half, w_qd, w_w_upd;
    logic [2:0]             w_sel, w_sel_abs;

    // Divisor multiples in residual scale: d, 0.5d, 1.5d.
    assign w_d1         = WW'(signed'({3'b000, r_d, 2'b00}));
    assign w_half       = WW'(signed'({4'b0000, r_d, 1'b0}));
    assign w_three_half = w_d1 + w_half;
    assign w_w4         = r_w <<< 2;
    assign w_w_upd      = w_w4 - w_qd;

    // Exact digit selection.
    always_comb begin
        w_sel     = 3'd0;
        w_sel_abs = 3'd0;
        w_qd      = '0;
        if (w_w4 >= w_three_half) begin
            w_sel     = 3'd2;
            w_sel_abs = 3'd2;
            w_qd      = w_d1 <<< 1;
        end else if (w_w4 >= w_half) begin
            w_sel     = 3'd1;
            w_sel_abs = 3'd1;
            w_qd      = w_d1;
        end else if (w_w4 >= -w_half) begin
            w_sel     = 3'd0;
            w_sel_abs = 3'd0;
            w_qd      = '0;
        end else if (w_w4 >= -w_three_half) begin
            w_sel     = 3'b111;
            w_sel_abs = 3'd1;
            w_qd      = -w_d1;
        end else begin
            w_sel     = 3'b110;
            w_sel_abs = 3'd2;
            w_qd      = -(w_d1 <<< 1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
        w_bad_nxt   = r_bad;
        w_q_nxt     = 3'd0;
        w_qabs_nxt  = 3'd0;
        w_ptr_nxt   = '0;
        w_ce_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = busy;
        w_rneg_nxt  = rem_neg;
        w_rzero_nxt = rem_zero;
        w_err_nxt   = div_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_nxt  = 1'b1;
                    w_rneg_nxt  = 1'b0;
                    w_rzero_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    if (divisor[WL-1]) begin
                        w_d_nxt     = divisor;
                        w_w_nxt     = WW'(signed'({5'b00000, dividend}));
                        w_bad_nxt   = 1'b0;
                        w_state_nxt = S_ITER;
                    end else begin
                        w_bad_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ITER: begin
                w_q_nxt    = w_sel;
                w_qabs_nxt = w_sel_abs;
                w_ptr_nxt  = r_cnt;
                w_ce_nxt   = 1'b1;
                w_w_nxt    = w_w_upd;
                w_cnt_nxt  = r_cnt + addpointer'(1);
                if (r_cnt == addpointer'(N - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_err_nxt   = r_bad;
                w_rneg_nxt  = ~r_bad & r_w[WW-1];
                w_rzero_nxt = ~r_bad & (r_w == '0);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_w      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_bad    <= 1'b0;
            q        <= 3'd0;
            q_abs    <= 3'd0;
            pointer  <= '0;
            CE       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rem_neg  <= 1'b0;
            rem_zero <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_w      <= w_w_nxt;
            r_d      <= w_d_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bad    <= w_bad_nxt;
            q        <= w_q_nxt;
            q_abs    <= w_qabs_nxt;
            pointer  <= w_ptr_nxt;
            CE       <= w_ce_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            rem_neg  <= w_rneg_nxt;
            rem_zero <= w_rzero_nxt;
            div_err  <= w_err_nxt;
        end
    end

endmodule
